// File: rtl/bp_dcache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_dcache_req_arbiter
// Brief    : Two-requester D$ port arbiter with a one-entry output buffer,
//            a load credit counter and an in-order response ID FIFO.
//            Optional macro BP_DCACHE_ARB_FIXED_PRIO_EN: port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module bp_dcache_req_arbiter #(
    parameter int vaddr_width_p = 39,
    parameter int data_width_p  = 64,
    parameter int outstanding_p = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [1:0]                    req_v_i,
    output logic [1:0]                    req_ready_o,
    input  logic [1:0][3:0]               req_opcode_i,
    input  logic [1:0][vaddr_width_p-1:0] req_addr_i,
    input  logic [1:0][data_width_p-1:0]  req_data_i,
    output logic                          dcache_pkt_v_o,
    input  logic                          dcache_ready_i,
    output logic [3:0]                    dcache_opcode_o,
    output logic [vaddr_width_p-1:0]      dcache_addr_o,
    output logic [data_width_p-1:0]       dcache_data_o,
    input  logic                          dcache_data_v_i,
    input  logic [data_width_p-1:0]       dcache_data_i,
    output logic [1:0]                    resp_v_o,
    output logic [data_width_p-1:0]       resp_data_o,
    output logic                          err_o
);

    localparam int c_pw = $clog2(outstanding_p);
    localparam int c_cw = c_pw + 1;
    localparam logic [c_cw-1:0] c_max_credits = c_cw'(outstanding_p);
    localparam logic [c_cw-1:0] c_credit_one  = c_cw'(1);
    localparam logic [c_pw:0]   c_ptr_one     = (c_pw + 1)'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

    buf_state_e                 r_state;
    logic [3:0]                 r_opcode;
    logic [vaddr_width_p-1:0]   r_addr;
    logic [data_width_p-1:0]    r_data;
    logic                       r_owner;
    logic [c_cw-1:0]            r_credits;
    logic [c_pw:0]              r_wptr;
    logic [c_pw:0]              r_rptr;
    logic [outstanding_p-1:0]   r_id_mem;
    logic                       r_err;

    logic                       w_drain;
    logic                       w_space;
    logic                       w_credit_ok;
    logic [1:0]                 w_legal;
    logic [1:0]                 w_is_load;
    logic [1:0]                 w_elig;
    logic [1:0]                 w_grant;
    logic [1:0]                 w_drop;
    logic                       w_pick1;
    logic                       w_any_grant;
    logic                       w_sel;
    logic                       w_grant_load;
    logic                       w_fifo_empty;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_head;

    assign w_drain     = (r_state == ST_FULL) & dcache_ready_i;
    assign w_space     = (r_state == ST_EMPTY) | w_drain;
    assign w_credit_ok = (r_credits < c_max_credits);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            // Legal: 0000-0110 (loads) and 10xx (stores)
            assign w_legal[gi]   = req_opcode_i[gi][3] ? ~req_opcode_i[gi][2]
                                                       : (req_opcode_i[gi] != 4'b0111);
            assign w_is_load[gi] = w_legal[gi] & ~req_opcode_i[gi][3];
            assign w_elig[gi]    = req_v_i[gi] & w_legal[gi] & w_space
                                 & (~w_is_load[gi] | w_credit_ok);
            assign w_drop[gi]    = req_v_i[gi] & ~w_legal[gi] & ~w_grant[1-gi];
        end
    endgenerate

`ifdef BP_DCACHE_ARB_FIXED_PRIO_EN
    assign w_pick1 = ~w_elig[0];
`else
    logic r_last;

    // Port 1 wins a tie only when port 0 took the previous grant
    assign w_pick1 = ~w_elig[0] | ~r_last;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_last <= 1'b1;
        end else if (w_any_grant) begin
            r_last <= w_sel;
        end
    end
`endif

    assign w_grant[1]   = w_elig[1] & w_pick1;
    assign w_grant[0]   = w_elig[0] & ~w_grant[1];
    assign w_any_grant  = |w_grant;
    assign w_sel        = w_grant[1];
    assign w_grant_load = w_any_grant & w_is_load[w_sel];
    assign req_ready_o  = w_grant | w_drop;

    assign w_fifo_empty = (r_wptr == r_rptr);
    assign w_push       = w_drain & ~r_opcode[3];
    assign w_pop        = dcache_data_v_i & ~w_fifo_empty;
    assign w_head       = r_id_mem[r_rptr[c_pw-1:0]];

    assign dcache_pkt_v_o  = (r_state == ST_FULL);
    assign dcache_opcode_o = r_opcode;
    assign dcache_addr_o   = r_addr;
    assign dcache_data_o   = r_data;
    assign resp_v_o        = {w_pop & w_head, w_pop & ~w_head};
    assign resp_data_o     = dcache_data_i;
    assign err_o           = r_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_EMPTY;
            r_opcode  <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_owner   <= 1'b0;
            r_credits <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_id_mem  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_any_grant) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_drain && !w_any_grant) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase

            if (w_any_grant) begin
                r_opcode <= req_opcode_i[w_sel];
                r_addr   <= req_addr_i[w_sel];
                r_data   <= req_data_i[w_sel];
                r_owner  <= w_sel;
            end

            if (w_push) begin
                r_id_mem[r_wptr[c_pw-1:0]] <= r_owner;
                r_wptr                     <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end

            // A spurious response (empty FIFO) must not return a credit
            case ({w_grant_load, w_pop})
                2'b10:   r_credits <= r_credits + c_credit_one;
                2'b01:   r_credits <= r_credits - c_credit_one;
                default: r_credits <= r_credits;
            endcase

            if ((|w_drop) || (dcache_data_v_i && w_fifo_empty)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/bp_dcache_req_arbiter.md
# bp_dcache_req_arbiter

Shares the single D$ request port between two requesters: port 0 is the BE load/store pipe, port 1 is the page-table walker. Requesters present (opcode, addr, data) packets using the D$ opcode encoding. The block arbitrates between them and buffers the granted packet in a one-entry output register. It tracks outstanding loads in order and routes each D$ load response back to the requester that issued it.

## Interface
- vaddr_width_p, 39: request address width.
- data_width_p, 64: store data / load response width.
- outstanding_p, 4: maximum loads in flight (buffered plus issued); power of two, ≥2.
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  2  per-requester valid.
- req_ready_o  out  2  per-requester ready; a transfer occurs when valid and ready are both high.
- req_opcode_i  in  2x4  D$ opcode per requester.
- req_addr_i  in  2 x vaddr_width_p  address per requester.
- req_data_i  in  2 x data_width_p  store data per requester.
- dcache_pkt_v_o  out  1  buffered packet valid.
- dcache_ready_i  in  1  D$ accepts the packet when dcache_pkt_v_o and dcache_ready_i are both high.
- dcache_opcode_o / dcache_addr_o / dcache_data_o  out  4 / vaddr_width_p / data_width_p  buffered packet fields.
- dcache_data_v_i  in  1  load response valid; responses return in issue order.
- dcache_data_i  in  data_width_p  load response data.
- resp_v_o  out  2  one-hot response valid to the owning requester.
- resp_data_o  out  data_width_p  response data, shared by both requesters.
- err_o  out  1  sticky error flag.

## Operation
- Legal opcodes: 0000–0110 (loads), 1000–1011 (stores). A load is any legal opcode with opcode[3]=0.
- Illegal opcodes (0111, 11xx) are handshaken and dropped. They never reach the output buffer, and they set err_o.
- Output buffer states: EMPTY and FULL.
  - EMPTY -> FULL on any legal grant.
  - FULL -> EMPTY on a D$ handshake with no new grant.
  - FULL -> FULL on a D$ handshake with a same-cycle grant (back-to-back).
- Grant eligibility for requester i requires all of the following:
  - req_v_i[i] is high.
  - The buffer is EMPTY or draining this cycle.
  - If the opcode is a load: load_credits < outstanding_p.
- Round-robin: with both requesters eligible, the requester that was not granted last wins. The last-grant pointer resets to 1, so port 0 wins first. Illegal-opcode drops do not update the pointer.
- req_ready_o[i] is high only for the winner, or for an illegal-opcode requester when the other requester is not granted.
- load_credits counts loads held in the buffer plus loads issued to D$ and not yet returned.
  - +1 on a load grant.
  - −1 on dcache_data_v_i.
  - A simultaneous grant and response leaves the count unchanged.
  - Eligibility uses the registered count, so a response does not free a credit in the same cycle.
- ID FIFO: depth outstanding_p, 1-bit requester ID.
  - Push when a load leaves the buffer on a D$ handshake.
  - Pop on dcache_data_v_i.
  - Pointers wrap modulo outstanding_p.
  - Push and pop in the same cycle are allowed in any state.
- Responses:
  - resp_v_o[fifo_head] = dcache_data_v_i.
  - resp_data_o = dcache_data_i, combinational.
- dcache_data_v_i with an empty FIFO: sets err_o, drives resp_v_o=0, and leaves the FIFO unchanged.
- Stores never produce responses and consume no credits.

## Timing
- Request handshake to dcache_pkt_v_o: 1 cycle (registered). Peak throughput is 1 packet per cycle.
- Buffered fields remain stable while dcache_pkt_v_o is high and dcache_ready_i is low.
- Response path has zero latency (combinational).
- Reset values:
  - dcache_pkt_v_o=0, resp_v_o=0, err_o=0.
  - Buffer EMPTY, load_credits=0, FIFO empty, RR pointer=1.
  - Data fields: 0.
- Reset mid-operation discards the buffer and all in-flight IDs. The D$ is reset in the same cycle.
- err_o clears only on reset.

## Configuration
- BP_DCACHE_ARB_FIXED_PRIO_EN
  - Defined: port 0 always wins when both requesters are eligible, and the RR pointer is removed.
  - Undefined: round-robin as described above.
- Credit, FIFO and error behaviour are identical in both modes.

## Test plan
- Single load, port 0: ld (0011) at 0x1000, D$ always ready.
  - Expected: dcache_pkt_v_o=1 on cycle+1 with opcode 0011.
  - Response 0xDEAD then asserts resp_v_o=01 with resp_data_o=0xDEAD.
- Contention: both ports hold sw (1010) continuously for 4 packets each.
  - RR mode: grant order 0,1,0,1,…
  - FIXED_PRIO_EN mode: all port 0 first.
  - Stores produce no resp_v_o.
- Credit limit: port 1 issues 5 lw (0010) with outstanding_p=4 and no responses returned.
  - Expected: req_ready_o[1]=0 on the 5th load.
  - One response returns with resp_v_o=10; the 5th load is granted on the following cycle.
- Ordering: port 0 lb, then port 1 lhu, then port 0 ld; responses A, B, C return.
  - Expected: resp_v_o sequence 01, 10, 01, with data A, B, C.
- Backpressure: dcache_ready_i=0 for 3 cycles with a packet buffered.
  - Expected: dcache_opcode_o/addr/data stable and req_ready_o=00.
  - Next handshake is back-to-back with no idle cycle.
- Errors: opcode 1100 from port 0 -> dropped, err_o=1 next cycle. Separately, after reset, dcache_data_v_i with no loads outstanding -> err_o=1 and resp_v_o=00.
